// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and parity mode constants shared by the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} rx_state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: serial input, sample tick and received-frame outputs of the oversampling receiver
interface uart_rx_os_if #(parameter int DBIT = 8) ();
  logic rx;
  logic s_tick;
  logic [DBIT-1:0] dout;
  logic rx_done_tick;
  logic frame_err;
  logic parity_err;
  logic busy;
  modport master (output rx, s_tick, input dout, rx_done_tick, frame_err, parity_err, busy);
  modport slave (input rx, s_tick, output dout, rx_done_tick, frame_err, parity_err, busy);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(parameter logic RST_VAL = 1'b1) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, m} <= {2{RST_VAL}};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, mid-bit sampling of start/data/parity/stop on s_tick
module uart_rx_os import uart_pkg::*; #(
  parameter int DBIT = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK = 16,
  parameter int PARITY = PARITY_NONE
) (
  input logic clk,
  input logic reset,
  uart_rx_os_if.slave bus
);
  localparam int SW = $clog2(OVERSAMPLE > SB_TICK ? OVERSAMPLE : SB_TICK);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  rx_state_t state;
  logic [SW-1:0] s;
  logic [NW-1:0] n;
  logic [DBIT-1:0] shift;
  logic par_bit, rx_s, rx_prev, par_odd;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(bus.rx), .q(rx_s));
  assign par_odd = ^{shift, par_bit};
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      shift <= '0;
      par_bit <= 1'b0;
      rx_prev <= 1'b1;
      bus.dout <= '0;
      bus.rx_done_tick <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      bus.rx_done_tick <= 1'b0;
      case (state)
        IDLE: if (rx_prev && !rx_s) begin
          state <= START;
          s <= '0;
        end
        START: if (bus.s_tick) begin
          if (s == S_MID) begin
            state <= rx_s ? IDLE : DATA;
            s <= '0;
            n <= '0;
          end else s <= s + 1'b1;
        end
        DATA: if (bus.s_tick) begin
          if (s == S_BIT) begin
            s <= '0;
            shift <= {rx_s, shift[DBIT-1:1]};
            if (n == N_LAST) state <= PARITY != PARITY_NONE ? PAR : STOP;
            else n <= n + 1'b1;
          end else s <= s + 1'b1;
        end
        PAR: if (bus.s_tick) begin
          if (s == S_BIT) begin
            par_bit <= rx_s;
            s <= '0;
            state <= STOP;
          end else s <= s + 1'b1;
        end
        STOP: if (bus.s_tick) begin
          // final stop tick: publish the frame so the done pulse lands on the next clock
          if (s == S_STOP) begin
            state <= IDLE;
            s <= '0;
            bus.rx_done_tick <= 1'b1;
            bus.dout <= shift;
            bus.frame_err <= ~rx_s;
            bus.parity_err <= PARITY == PARITY_ODD ? ~par_odd : PARITY == PARITY_EVEN ? par_odd : 1'b0;
          end else s <= s + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: randomized frame stimulus checked against a per-frame expectation model
module tb_uart_rx_os;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] tcnt = 2'd0;
  logic tick;
  int compared = 0, mismatched = 0;
  typedef struct {logic [7:0] d; logic fe; logic pe;} rec_t;
  rec_t got1[$], got2[$];
  rec_t r;
  logic [7:0] last_d;
  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign tick = tcnt == 2'd3;
  uart_rx_os_if #(.DBIT(8)) b1 ();
  uart_rx_os_if #(.DBIT(8)) b2 ();
  assign b1.s_tick = tick;
  assign b2.s_tick = tick;
  uart_rx_os #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  uart_rx_os #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  always @(negedge clk) begin
    if (b1.rx_done_tick) got1.push_back('{b1.dout, b1.frame_err, b1.parity_err});
    if (b2.rx_done_tick) got2.push_back('{b2.dout, b2.frame_err, b2.parity_err});
  end
  // even parity: total ones across data and parity bit must be even
  function automatic logic exp_pe(input logic [7:0] d, input logic par);
    return (($countones(d) + int'(par)) % 2) != 0;
  endfunction
  task automatic drive(input bit p, input logic v, input int ticks);
    if (p) b2.rx = v; else b1.rx = v;
    repeat (ticks * 4) @(negedge clk);
  endtask
  task automatic send(input bit p, input logic [7:0] d, input logic par, input logic stop);
    drive(p, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(p, d[i], 16);
    if (p) drive(p, par, 16);
    drive(p, stop, 16);
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++;
    if (b1.dout !== 8'h00 || b1.rx_done_tick !== 1'b0 || b1.frame_err !== 1'b0 || b1.parity_err !== 1'b0 || b1.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_dut1: dout=%h done=%b fe=%b pe=%b busy=%b, want all 0", b1.dout, b1.rx_done_tick, b1.frame_err, b1.parity_err, b1.busy);
    end
    compared++;
    if (b2.dout !== 8'h00 || b2.parity_err !== 1'b0 || b2.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_dut2: dout=%h pe=%b busy=%b, want all 0", b2.dout, b2.parity_err, b2.busy);
    end
    reset = 1'b0;
    drive(0, 1'b1, 4);
  endtask
  task automatic test_single;
    logic [7:0] d;
    for (int k = 0; k < 5; k++) begin
      d = k == 0 ? 8'h55 : 8'($urandom);
      got1.delete();
      send(0, d, 1'b0, 1'b1);
      drive(0, 1'b1, 4);
      compared++;
      if (got1.size() != 1) begin
        mismatched++;
        $display("FAIL single_count[%0d]: %0d pulses, want 1", k, got1.size());
      end else begin
        r = got1.pop_front();
        compared++;
        if (r.d !== d || r.fe !== 1'b0 || r.pe !== 1'b0) begin
          mismatched++;
          $display("FAIL single_data[%0d]: dout=%h fe=%b pe=%b, want %h 0 0", k, r.d, r.fe, r.pe, d);
        end
      end
      compared++;
      if (b1.busy !== 1'b0) begin
        mismatched++;
        $display("FAIL single_busy[%0d]: busy=%b, want 0", k, b1.busy);
      end
      last_d = d;
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] q[4];
    q[0] = 8'hA3; q[1] = 8'h0F; q[2] = 8'($urandom); q[3] = 8'($urandom);
    got1.delete();
    for (int k = 0; k < 4; k++) send(0, q[k], 1'b0, 1'b1);
    drive(0, 1'b1, 8);
    compared++;
    if (got1.size() != 4) begin
      mismatched++;
      $display("FAIL b2b_count: %0d pulses, want 4", got1.size());
    end
    for (int k = 0; k < 4 && got1.size() > 0; k++) begin
      r = got1.pop_front();
      compared++;
      if (r.d !== q[k] || r.fe !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_data[%0d]: dout=%h fe=%b, want %h 0", k, r.d, r.fe, q[k]);
      end
    end
    last_d = q[3];
  endtask
  task automatic test_glitch;
    got1.delete();
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 40);
    compared++;
    if (got1.size() != 0 || b1.dout !== last_d || b1.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch: pulses=%0d dout=%h busy=%b, want 0 %h 0", got1.size(), b1.dout, b1.busy, last_d);
    end
  endtask
  task automatic test_break;
    logic [7:0] q[2];
    q[0] = 8'h3C; q[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      got1.delete();
      send(0, q[k], 1'b0, 1'b0);
      drive(0, 1'b0, 150);
      compared++;
      if (got1.size() != 1) begin
        mismatched++;
        $display("FAIL break_count[%0d]: %0d pulses, want 1", k, got1.size());
      end else begin
        r = got1.pop_front();
        compared++;
        if (r.d !== q[k] || r.fe !== 1'b1) begin
          mismatched++;
          $display("FAIL break_data[%0d]: dout=%h fe=%b, want %h 1", k, r.d, r.fe, q[k]);
        end
      end
      compared++;
      if (b1.busy !== 1'b0) begin
        mismatched++;
        $display("FAIL break_idle[%0d]: busy=%b while line low, want 0", k, b1.busy);
      end
      drive(0, 1'b1, 8);
    end
  endtask
  task automatic test_parity;
    logic [7:0] d;
    logic p;
    for (int k = 0; k < 6; k++) begin
      d = k < 2 ? 8'h07 : 8'($urandom);
      p = k < 2 ? k[0] : 1'($urandom);
      got2.delete();
      send(1, d, p, 1'b1);
      drive(1, 1'b1, 4);
      compared++;
      if (got2.size() != 1) begin
        mismatched++;
        $display("FAIL parity_count[%0d]: %0d pulses, want 1", k, got2.size());
      end else begin
        r = got2.pop_front();
        compared++;
        if (r.d !== d || r.fe !== 1'b0 || r.pe !== exp_pe(d, p)) begin
          mismatched++;
          $display("FAIL parity_data[%0d]: dout=%h fe=%b pe=%b, want %h 0 %b", k, r.d, r.fe, r.pe, d, exp_pe(d, p));
        end
      end
    end
  endtask
  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'($urandom) | 8'h01;
    got1.delete();
    send(0, d, 1'b0, 1'b0);
    drive(0, 1'b1, 8);
    compared++;
    if (got1.size() != 1 || b1.dout !== d || b1.frame_err !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_pre: pulses=%0d dout=%h fe=%b, want 1 %h 1", got1.size(), b1.dout, b1.frame_err, d);
    end
    got1.delete();
    drive(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 16);
    drive(0, 1'b0, 8);
    compared++;
    if (b1.busy !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_busy: busy=%b mid-frame, want 1", b1.busy);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (b1.dout !== 8'h00 || b1.frame_err !== 1'b0 || b1.rx_done_tick !== 1'b0 || b1.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_clear: dout=%h fe=%b done=%b busy=%b, want all 0", b1.dout, b1.frame_err, b1.rx_done_tick, b1.busy);
    end
    b1.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b1, 4);
    send(0, 8'h81, 1'b0, 1'b1);
    drive(0, 1'b1, 4);
    compared++;
    if (got1.size() != 1) begin
      mismatched++;
      $display("FAIL rstmid_count: %0d pulses, want 1", got1.size());
    end else begin
      r = got1.pop_front();
      compared++;
      if (r.d !== 8'h81 || r.fe !== 1'b0) begin
        mismatched++;
        $display("FAIL rstmid_data: dout=%h fe=%b, want 81 0", r.d, r.fe);
      end
    end
  endtask
  initial begin
    b1.rx = 1'b1;
    b2.rx = 1'b1;
    last_d = 8'h00;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_parity;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
